// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port 1024x18 data memory (A = CPU, B = DMA/loader).
// Optional ARB_ROUND_ROBIN_EN: IDLE ties alternate; otherwise A always wins a tie.
module data_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data,
  output logic [1:0]        dbg_state,
  output logic              dbg_last_grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Handshake: a requester holds req and a stable command until its one-cycle
  // ack; the owner's req seen during RESP is stale and never re-grants it.
  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic                r_cmd_we;
  logic                r_cmd_owner;   // 0 = A, 1 = B
  logic                r_last_grant;  // 0 = A, 1 = B
  logic [DATA_W-1:0]   r_rdata;

  logic                w_load;
  logic                w_sel_b;
  logic                w_tie_b;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_tie_b = ~r_last_grant;
`else
  assign w_tie_b = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_sel_b      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_load       = 1'b1;
          w_next_state = S_ACCESS;
          w_sel_b      = (a_req && b_req) ? w_tie_b : b_req;
        end
      end
      S_ACCESS: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
        if (!r_cmd_owner && b_req) begin
          w_load       = 1'b1;
          w_sel_b      = 1'b1;
          w_next_state = S_ACCESS;
        end else if (r_cmd_owner && a_req) begin
          w_load       = 1'b1;
          w_sel_b      = 1'b0;
          w_next_state = S_ACCESS;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_sel_we    = w_sel_b ? b_we    : a_we;
  assign w_sel_addr  = w_sel_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_sel_b ? b_wdata : a_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_cmd_we     <= 1'b0;
      r_cmd_owner  <= 1'b0;
      r_last_grant <= 1'b1;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_cmd_addr   <= w_sel_addr;
        r_cmd_wdata  <= w_sel_wdata;
        r_cmd_we     <= w_sel_we;
        r_cmd_owner  <= w_sel_b;
        r_last_grant <= w_sel_b;
      end
      // Read data is captured on the edge that ends ACCESS; writes leave it alone.
      if (r_state == S_ACCESS && !r_cmd_we) begin
        r_rdata <= mem_out_data;
      end
    end
  end

  // Enables decode from state only, so an async reset drops them immediately.
  assign mem_write_en   = (r_state == S_ACCESS) &&  r_cmd_we;
  assign mem_read_en    = (r_state == S_ACCESS) && !r_cmd_we;
  assign mem_address    = r_cmd_addr;
  assign mem_in_data    = r_cmd_wdata;
  assign a_ack          = (r_state == S_RESP) && !r_cmd_owner;
  assign b_ack          = (r_state == S_RESP) &&  r_cmd_owner;
  assign busy           = (r_state != S_IDLE);
  assign rdata          = r_rdata;
  assign dbg_state      = r_state;
  assign dbg_last_grant = r_last_grant;

endmodule
